// File: rtl/rmii_transmitter.sv
// rmii_transmitter: byte stream to RMII dibit transmitter (preamble, SFD,
// payload LSB-first, inter-frame gap). tx_en/tx0/tx1 come straight from flops.
// Optional build macro RMII_TX_PAD_EN: short frames are padded with 0x00 up
// to 60 payload bytes before the gap.
module rmii_transmitter #(
    parameter int IFG_CYCLES     = 48,
    parameter int PREAMBLE_BYTES = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_byte,
    input  logic       tx_valid,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic       tx_en,
    output logic       tx0,
    output logic       tx1,
    output logic       busy,
    output logic       underrun
);
    localparam int IFG_W = $clog2(IFG_CYCLES + 1);
    localparam int PRE_W = $clog2(PREAMBLE_BYTES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREAMBLE,
        S_SFD,
        S_DATA,
`ifdef RMII_TX_PAD_EN
        S_PAD,
`endif
        S_IFG
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       dcnt_q, dcnt_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [IFG_W-1:0] ifg_q, ifg_d;
    logic [7:0]       byte_q, byte_d;
    logic             last_q, last_d;
    logic             tx_en_d;
    logic [1:0]       dib_d;
`ifdef RMII_TX_PAD_EN
    logic [6:0]       cnt_q, cnt_d;
`endif

    assign busy = (state_q != S_IDLE);

    // Next-state, counters, handshake; the output dibit is derived from the
    // next state so the output flops present it on the following clock.
    always_comb begin
        state_d  = state_q;
        dcnt_d   = dcnt_q;
        pre_d    = pre_q;
        ifg_d    = ifg_q;
        byte_d   = byte_q;
        last_d   = last_q;
`ifdef RMII_TX_PAD_EN
        cnt_d    = cnt_q;
`endif
        tx_ready = 1'b0;
        underrun = 1'b0;
        tx_en_d  = 1'b0;
        dib_d    = 2'b00;

        case (state_q)
            S_IDLE: begin
                tx_ready = 1'b1;
                if (tx_valid) begin
                    byte_d  = tx_byte;
                    last_d  = tx_last;
                    dcnt_d  = 2'd0;
                    pre_d   = '0;
                    ifg_d   = '0;
`ifdef RMII_TX_PAD_EN
                    cnt_d   = '0;
`endif
                    state_d = S_PREAMBLE;
                end
            end
            S_PREAMBLE: begin
                dcnt_d = dcnt_q + 2'd1;
                if (dcnt_q == 2'd3) begin
                    if (pre_q == PRE_W'(PREAMBLE_BYTES - 1)) state_d = S_SFD;
                    else pre_d = pre_q + PRE_W'(1);
                end
            end
            S_SFD: begin
                dcnt_d = dcnt_q + 2'd1;
                if (dcnt_q == 2'd3) state_d = S_DATA;
            end
            S_DATA: begin
                dcnt_d = dcnt_q + 2'd1;
                if (dcnt_q == 2'd3) begin
`ifdef RMII_TX_PAD_EN
                    cnt_d = (cnt_q == 7'h7F) ? cnt_q : cnt_q + 7'd1;
`endif
                    if (last_q) begin
`ifdef RMII_TX_PAD_EN
                        // cnt_q excludes this byte, so < 59 means < 60 sent
                        state_d = (cnt_q < 7'd59) ? S_PAD : S_IFG;
`else
                        state_d = S_IFG;
`endif
                    end else begin
                        tx_ready = 1'b1;
                        if (tx_valid) begin
                            byte_d = tx_byte;
                            last_d = tx_last;
                        end else begin
                            // upstream starved us: truncate the frame
                            underrun = 1'b1;
                            state_d  = S_IFG;
                        end
                    end
                end
            end
`ifdef RMII_TX_PAD_EN
            S_PAD: begin
                dcnt_d = dcnt_q + 2'd1;
                if (dcnt_q == 2'd3) begin
                    cnt_d = (cnt_q == 7'h7F) ? cnt_q : cnt_q + 7'd1;
                    if (cnt_q >= 7'd59) state_d = S_IFG;
                end
            end
`endif
            S_IFG: begin
                if (ifg_q == IFG_W'(IFG_CYCLES - 1)) state_d = S_IDLE;
                else ifg_d = ifg_q + IFG_W'(1);
            end
            default: state_d = S_IDLE;
        endcase

        case (state_d)
            S_PREAMBLE: begin
                tx_en_d = 1'b1;
                dib_d   = 2'b01;
            end
            S_SFD: begin
                tx_en_d = 1'b1;
                dib_d   = (dcnt_d == 2'd3) ? 2'b11 : 2'b01;
            end
            S_DATA: begin
                tx_en_d = 1'b1;
                dib_d   = byte_d[{dcnt_d, 1'b0} +: 2];
            end
`ifdef RMII_TX_PAD_EN
            S_PAD: tx_en_d = 1'b1;
`endif
            default: ;
        endcase
    end

    // State, counters and registered RMII outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            dcnt_q  <= 2'd0;
            pre_q   <= '0;
            ifg_q   <= '0;
            byte_q  <= 8'h00;
            last_q  <= 1'b0;
            tx_en   <= 1'b0;
            tx0     <= 1'b0;
            tx1     <= 1'b0;
`ifdef RMII_TX_PAD_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            dcnt_q  <= dcnt_d;
            pre_q   <= pre_d;
            ifg_q   <= ifg_d;
            byte_q  <= byte_d;
            last_q  <= last_d;
            tx_en   <= tx_en_d;
            tx0     <= dib_d[0];
            tx1     <= dib_d[1];
`ifdef RMII_TX_PAD_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_rmii_transmitter.sv
// tb_rmii_transmitter: drives frames (directed and random) and compares the
// RMII output stream with a frame-level model built from byte lists.
`timescale 1ns/1ps
module tb_rmii_transmitter;
    localparam int P   = 7;
    localparam int IFG = 48;
`ifdef RMII_TX_PAD_EN
    localparam bit PAD_EN = 1'b1;
`else
    localparam bit PAD_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] tx_byte = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_last = 1'b0;
    logic       tx_ready, tx_en, tx0, tx1, busy, underrun;

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    logic [7:0] frame_q[$];
    logic [2:0] exp_q[$];
    logic [2:0] obs_q[$];
    int und_idx, und_cnt, rdy_cnt, acc_cnt, end_rdy;

    rmii_transmitter #(.IFG_CYCLES(IFG), .PREAMBLE_BYTES(P)) dut (
        .clk      (clk),
        .reset    (reset),
        .tx_byte  (tx_byte),
        .tx_valid (tx_valid),
        .tx_last  (tx_last),
        .tx_ready (tx_ready),
        .tx_en    (tx_en),
        .tx0      (tx0),
        .tx1      (tx1),
        .busy     (busy),
        .underrun (underrun)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Expected {tx_en, dibit} per cycle from the cycle after first accept
    // through the end of the gap.
    task automatic build_expected(input int n_sent, input bit complete);
        exp_q.delete();
        repeat (4 * P) exp_q.push_back(3'b101);
        repeat (3) exp_q.push_back(3'b101);
        exp_q.push_back(3'b111);
        for (int i = 0; i < n_sent; i++)
            for (int k = 0; k < 4; k++)
                exp_q.push_back({1'b1, 2'((int'(frame_q[i]) >> (2 * k)) & 3)});
        if (PAD_EN && complete && n_sent < 60)
            repeat (4 * (60 - n_sent)) exp_q.push_back(3'b100);
        repeat (IFG) exp_q.push_back(3'b000);
    endtask

    // Send frame_q; drop > 0 stops supplying after that many bytes.
    // hold keeps tx_valid high whenever tx_ready is low.
    task automatic run_frame(input string name, input int drop, input bit hold);
        int  len;
        int  supply;
        int  idx;
        int  cyc;
        int  mm;
        bit  started;
        bit  done;
        len     = frame_q.size();
        supply  = (drop > 0) ? drop : len;
        idx     = 0;
        cyc     = 0;
        started = 1'b0;
        done    = 1'b0;
        obs_q.delete();
        und_idx = -1; und_cnt = 0; rdy_cnt = 0; acc_cnt = 0; end_rdy = 0;
        while (!done && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            if (started && !busy) begin
                end_rdy  = int'(tx_ready);
                tx_valid = 1'b0;
                done     = 1'b1;
            end else begin
                if (tx_ready) begin
                    tx_valid = (idx < supply);
                    tx_byte  = (idx < len) ? frame_q[idx] : 8'($urandom);
                    tx_last  = (idx == len - 1);
                end else begin
                    tx_valid = hold ? 1'b1 : 1'($urandom);
                    tx_byte  = 8'($urandom);
                    tx_last  = 1'($urandom);
                end
                #1;
                if (started) begin
                    if (underrun) begin
                        und_cnt++;
                        if (und_idx < 0) und_idx = obs_q.size();
                    end
                    if (tx_ready) rdy_cnt++;
                    if (tx_ready && tx_valid) acc_cnt++;
                    obs_q.push_back({tx_en, tx1, tx0});
                end
                if (tx_ready && tx_valid) begin
                    started = 1'b1;
                    idx++;
                end
            end
        end
        tx_valid = 1'b0;

        build_expected(supply, drop == 0);
        mm = -1;
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
            if (mm < 0 && obs_q[i] !== exp_q[i]) mm = i;
        check({name, " finished"}, int'(done), 1);
        check({name, " cycles"}, obs_q.size(), exp_q.size());
        check({name, " first bad cycle"}, mm, -1);
        check({name, " ready pulses"}, rdy_cnt, (drop > 0) ? drop : len - 1);
        check({name, " accepts"}, acc_cnt, supply - 1);
        check({name, " underruns"}, und_cnt, (drop > 0) ? 1 : 0);
        check({name, " underrun cycle"}, und_idx, (drop > 0) ? 4 * P + 4 * drop + 3 : -1);
        check({name, " ready after gap"}, end_rdy, 1);
    endtask

    initial begin
        int         len;
        int         drop;
        int         en_cnt;
        logic [7:0] pay;

        repeat (3) @(negedge clk);
        check("reset tx_en", int'(tx_en), 0);
        check("reset dibit", int'({tx1, tx0}), 0);
        check("reset busy", int'(busy), 0);
        check("reset tx_ready", int'(tx_ready), 1);
        check("reset underrun", int'(underrun), 0);
        reset = 1'b0;

        // single byte 0xA7
        frame_q.delete();
        frame_q.push_back(8'hA7);
        run_frame("one_byte", 0, 1'b0);
        pay = {obs_q[4*P+4][1:0], obs_q[4*P+5][1:0], obs_q[4*P+6][1:0], obs_q[4*P+7][1:0]};
        check("one_byte dibits", int'(pay), int'(8'b11_01_10_10));

        // three bytes, valid held
        frame_q.delete();
        frame_q.push_back(8'h01);
        frame_q.push_back(8'h02);
        frame_q.push_back(8'h03);
        run_frame("three_byte", 0, 1'b1);
        en_cnt = 0;
        foreach (obs_q[i]) if (obs_q[i][2]) en_cnt++;
        check("three_byte payload en cycles", en_cnt - (4 * P + 4), PAD_EN ? 240 : 12);

        // underrun after byte 2 of 5
        frame_q.delete();
        repeat (5) frame_q.push_back(8'($urandom));
        run_frame("underrun", 2, 1'b0);

        // reset during SFD aborts the frame without a gap
        @(negedge clk);
        tx_valid = 1'b1;
        tx_byte  = 8'h5A;
        tx_last  = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (4 * P + 1) @(negedge clk);
        check("sfd busy", int'(busy), 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort tx_en", int'(tx_en), 0);
        check("abort busy", int'(busy), 0);
        check("abort tx_ready", int'(tx_ready), 1);
        check("abort dibit", int'({tx1, tx0}), 0);
        frame_q.delete();
        frame_q.push_back(8'hC3);
        frame_q.push_back(8'h3C);
        run_frame("after_abort", 0, 1'b0);

        // 64-byte frame, valid held through the gap
        frame_q.delete();
        repeat (64) frame_q.push_back(8'($urandom));
        run_frame("long64", 0, 1'b1);

        // random frames
        for (int r = 0; r < 6; r++) begin
            len  = $urandom_range(1, 12);
            drop = (len > 1 && $urandom_range(0, 2) == 0) ? $urandom_range(1, len - 1) : 0;
            frame_q.delete();
            repeat (len) frame_q.push_back(8'($urandom));
            run_frame($sformatf("rand%0d", r), drop, 1'($urandom));
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
